vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port VRAM between four requesters: CPU bus interface, layer 1 renderer, layer 2 renderer and sprite renderer.
- The three display requesters are the fetch engines that fill the line buffers read by the composer.
- Pipelined single-cycle grant, registered memory strobes, 1-cycle memory read latency; returned read data is tagged back to the issuing source.
- CPU has priority but is throttled so display fetch cannot starve.

Parameters:
- CPU_MAX_BURST, 4, max consecutive CPU grants while any display requester is pending (1..15).
- ADDR_W, 15, VRAM word address width (32-bit words; 128 KB).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, level, held until ack
- cpu_addr  in  17  CPU byte address
- cpu_write  in  1  1=write, 0=read
- cpu_wrdata  in  8  CPU write byte
- cpu_ack  out  1  request accepted this cycle
- cpu_rddata  out  8  byte selected by registered cpu_addr[1:0]
- cpu_rddata_valid  out  1  one-cycle pulse
- l1_req, l2_req, spr_req  in  1 each  display fetch request, level, held until ack, read-only
- l1_addr, l2_addr, spr_addr  in  ADDR_W each  word address
- l1_ack, l2_ack, spr_ack  out  1 each  request accepted this cycle
- fetch_rddata  out  32  shared read-data bus for display requesters
- l1_rddata_valid, l2_rddata_valid, spr_rddata_valid  out  1 each  one-cycle pulse qualifying fetch_rddata
- vram_addr  out  ADDR_W  registered word address
- vram_wrdata  out  32  cpu_wrdata replicated to 4 lanes
- vram_wrbytesel  out  4  one-hot from cpu_addr[1:0], write only
- vram_write  out  1  write strobe
- vram_rddata  in  32  valid one cycle after a read strobe on vram_addr

Behaviour:
- Reset: all acks 0, all rddata_valid 0, vram_write 0, vram_wrbytesel 0, vram_addr 0, cpu_rddata 0, fetch_rddata 0, burst counter 0, round-robin pointer = l1.
- Cycle T (combinational grant): at most one ack high.
  - If cpu_req and the CPU is not throttled, grant CPU.
  - Otherwise grant the first pending display requester starting at the rr pointer, in order l1 -> l2 -> spr -> l1.
  - ack = req & grant; a requester may present its next request at T+1, so back-to-back grants are allowed.
- Cycle T+1 (registered):
  - vram_addr = granted address; CPU uses cpu_addr[16:2].
  - vram_write = cpu write; vram_wrbytesel = 1 << cpu_addr[1:0] on a write, else 0.
  - Source tag and byte offset register alongside.
  - No grant at T: vram_write = 0, tag = none, vram_addr holds.
- Cycle T+2 (reads only):
  - vram_rddata registered into fetch_rddata or cpu_rddata.
  - Exactly one matching *_rddata_valid pulses. CPU writes never pulse valid.
- Throttle:
  - Burst counter increments on each CPU grant while any display req is high.
  - It clears on any display grant, or on any cycle with no display req.
  - Counter == CPU_MAX_BURST throttles CPU: the next pending display requester is granted.
  - If no display req is pending, CPU is never throttled.
- RR pointer moves to the source after the display winner, updated only on a display grant.
- Idle (no req): no ack, pipeline drains, no spurious valid.
- rst_n asserted mid-operation: in-flight tags are discarded, no valid pulses after release, and the first grant follows normal priority.
- Throughput: one access per cycle, sustained.

Decomposition:
- Shared package: source-tag constants (TAG_NONE, TAG_CPU, TAG_L1, TAG_L2, TAG_SPR), ADDR_W default.
- One sub-module, rr_arbiter3: 3-way round-robin grant with pointer register, reused for display requesters.

Test Plan:
- Only l1_req with addr 0x0100, mem model returning 0xDEADBEEF:
  - l1_ack same cycle; vram_addr = 0x0100 at T+1.
  - l1_rddata_valid with fetch_rddata = 0xDEADBEEF at T+2.
- l1, l2 and spr requesting continuously for 6 cycles -> grant order l1, l2, spr, l1, l2, spr.
- cpu_req held as a write stream plus l2_req held, CPU_MAX_BURST = 4 -> pattern CPU×4, l2, CPU×4, l2.
- CPU write addr 0x00006, data 0xA5 -> vram_addr = 0x0001, wrbytesel = 4'b0100, wrdata = 0xA5A5A5A5, no valid pulse.
- CPU read addr 0x00003 with memory word 0x11223344 -> cpu_rddata_valid at T+2 with cpu_rddata = 0x11.
- Reads issued on consecutive cycles, rst_n low at T+1 -> no valid pulses, all outputs at reset values.
- After release, a fresh l1 request completes normally.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: source tags carried down the
// read pipeline and the default VRAM word-address width.
package vram_arbiter_pkg;

    localparam int DEF_ADDR_W = 15;

    typedef enum logic [2:0] {
        TAG_NONE = 3'd0,
        TAG_CPU  = 3'd1,
        TAG_L1   = 3'd2,
        TAG_L2   = 3'd3,
        TAG_SPR  = 3'd4
    } tag_t;

endpackage

// File: rtl/vram_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter for the display fetch engines.
// Index 0 = layer 1, 1 = layer 2, 2 = sprites. The pointer names the
// requester with highest priority and moves past each winner.
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic       i_en,
    output logic [2:0] o_grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_win;
    logic       w_fire;

    function automatic logic [1:0] first_of(input logic [2:0] req,
                                            input logic [1:0] a,
                                            input logic [1:0] b,
                                            input logic [1:0] c);
        if (req[a]) return a;
        if (req[b]) return b;
        return c;
    endfunction

    // Pick the first pending requester starting from the pointer.
    always_comb begin
        case (r_ptr)
            2'd0:    w_win = first_of(i_req, 2'd0, 2'd1, 2'd2);
            2'd1:    w_win = first_of(i_req, 2'd1, 2'd2, 2'd0);
            default: w_win = first_of(i_req, 2'd2, 2'd0, 2'd1);
        endcase
    end

    assign w_fire  = i_en && (|i_req);
    assign o_grant = w_fire ? (3'b001 << w_win) : 3'b000;

    // Advance the pointer to the source after the winner, only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_fire) begin
            r_ptr <= (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: CPU plus three display fetch engines share one
// single-port VRAM. Grant is combinational, memory strobes are
// registered, and read data returns two cycles after grant tagged
// to its source. The CPU wins unless its burst budget is spent while
// display fetch is waiting.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int CPU_MAX_BURST = 4,
    parameter int ADDR_W        = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [16:0]       cpu_addr,
    input  logic              cpu_write,
    input  logic [7:0]        cpu_wrdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rddata,
    output logic              cpu_rddata_valid,
    input  logic              l1_req,
    input  logic [ADDR_W-1:0] l1_addr,
    output logic              l1_ack,
    input  logic              l2_req,
    input  logic [ADDR_W-1:0] l2_addr,
    output logic              l2_ack,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              spr_ack,
    output logic [31:0]       fetch_rddata,
    output logic              l1_rddata_valid,
    output logic              l2_rddata_valid,
    output logic              spr_rddata_valid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_wrdata,
    output logic [3:0]        vram_wrbytesel,
    output logic              vram_write,
    input  logic [31:0]       vram_rddata
);

    logic [3:0]        r_burst;
    logic [2:0]        w_disp_req;
    logic [2:0]        w_disp_gnt;
    logic              w_any_disp;
    logic              w_throttle;
    logic              w_cpu_gnt;
    logic              w_disp_en;
    logic              w_disp_any_gnt;

    logic [ADDR_W-1:0] w_addr;
    tag_t              w_tag;
    logic              w_write;
    logic [3:0]        w_bytesel;

    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_vram_write;
    logic [3:0]        r_wrbytesel;
    logic [31:0]       r_wrdata;
    tag_t              r_tag;
    logic [1:0]        r_off;

    logic [31:0]       r_fetch_rddata;
    logic [7:0]        r_cpu_rddata;
    logic              r_cpu_vld;
    logic              r_l1_vld;
    logic              r_l2_vld;
    logic              r_spr_vld;

    function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                            input logic [1:0]  off);
        case (off)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    assign w_disp_req     = {spr_req, l2_req, l1_req};
    assign w_any_disp     = |w_disp_req;
    // Throttle only bites when a display requester is actually waiting.
    assign w_throttle     = w_any_disp && (r_burst == 4'(CPU_MAX_BURST));
    // No grants while reset is held, so nothing enters the pipeline.
    assign w_cpu_gnt      = rst_n && cpu_req && !w_throttle;
    assign w_disp_en      = rst_n && !w_cpu_gnt;
    assign w_disp_any_gnt = |w_disp_gnt;

    rr_arbiter3 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_disp_req),
        .i_en    (w_disp_en),
        .o_grant (w_disp_gnt)
    );

    assign cpu_ack = w_cpu_gnt;
    assign l1_ack  = w_disp_gnt[0];
    assign l2_ack  = w_disp_gnt[1];
    assign spr_ack = w_disp_gnt[2];

    // Count CPU grants made while display fetch waits; any display grant
    // or a cycle with no display demand restarts the budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= 4'd0;
        end else if (w_disp_any_gnt || !w_any_disp) begin
            r_burst <= 4'd0;
        end else if (w_cpu_gnt) begin
            r_burst <= r_burst + 4'd1;
        end
    end

    // Select the winner's address and strobes; idle cycles hold the address.
    always_comb begin
        w_addr    = r_vram_addr;
        w_tag     = TAG_NONE;
        w_write   = 1'b0;
        w_bytesel = 4'b0000;
        if (w_cpu_gnt) begin
            w_addr  = ADDR_W'(cpu_addr[16:2]);
            w_write = cpu_write;
            if (cpu_write) begin
                w_bytesel = 4'b0001 << cpu_addr[1:0];
            end else begin
                w_tag = TAG_CPU;
            end
        end else if (w_disp_gnt[0]) begin
            w_addr = l1_addr;
            w_tag  = TAG_L1;
        end else if (w_disp_gnt[1]) begin
            w_addr = l2_addr;
            w_tag  = TAG_L2;
        end else if (w_disp_gnt[2]) begin
            w_addr = spr_addr;
            w_tag  = TAG_SPR;
        end
    end

    // Memory strobe stage: register address, write strobes and source tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vram_addr  <= '0;
            r_vram_write <= 1'b0;
            r_wrbytesel  <= 4'b0000;
            r_wrdata     <= 32'h0;
            r_tag        <= TAG_NONE;
            r_off        <= 2'd0;
        end else begin
            r_vram_addr  <= w_addr;
            r_vram_write <= w_write;
            r_wrbytesel  <= w_bytesel;
            r_tag        <= w_tag;
            if (w_cpu_gnt) begin
                r_off <= cpu_addr[1:0];
            end
            if (w_cpu_gnt && cpu_write) begin
                r_wrdata <= {4{cpu_wrdata}};
            end
        end
    end

    // Read return stage: capture VRAM data for the tagged source and pulse its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_rddata <= 32'h0;
            r_cpu_rddata   <= 8'h0;
            r_cpu_vld      <= 1'b0;
            r_l1_vld       <= 1'b0;
            r_l2_vld       <= 1'b0;
            r_spr_vld      <= 1'b0;
        end else begin
            r_cpu_vld <= (r_tag == TAG_CPU);
            r_l1_vld  <= (r_tag == TAG_L1);
            r_l2_vld  <= (r_tag == TAG_L2);
            r_spr_vld <= (r_tag == TAG_SPR);
            if (r_tag == TAG_CPU) begin
                r_cpu_rddata <= sel_byte(vram_rddata, r_off);
            end
            if (r_tag == TAG_L1 || r_tag == TAG_L2 || r_tag == TAG_SPR) begin
                r_fetch_rddata <= vram_rddata;
            end
        end
    end

    assign vram_addr        = r_vram_addr;
    assign vram_write       = r_vram_write;
    assign vram_wrbytesel   = r_wrbytesel;
    assign vram_wrdata      = r_wrdata;
    assign fetch_rddata     = r_fetch_rddata;
    assign cpu_rddata       = r_cpu_rddata;
    assign cpu_rddata_valid = r_cpu_vld;
    assign l1_rddata_valid  = r_l1_vld;
    assign l2_rddata_valid  = r_l2_vld;
    assign spr_rddata_valid = r_spr_vld;

endmodule
